// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED envelope generator: phase
// encoding, default parameter values and small width/level helpers.
// The optional gamma stage is controlled by the BREATH_GAMMA_EN macro.
package breath_pkg;

    // Envelope phases; encoding is visible on the phase output.
    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_e;

    localparam int DEF_PWM_BITS   = 16;
    localparam int DEF_PRESCALE   = 256;
    localparam int DEF_HOLD_STEPS = 64;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full-scale level for a given duty width (2^bits - 1).
    function automatic logic [63:0] lmax(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/gamma_sq.sv
// Registered squarer for perceptual brightness correction. Returns the
// upper half of level*level, so full scale maps to full scale minus one.
// Only instantiated when BREATH_GAMMA_EN is defined.
module gamma_sq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [2*W-1:0] prod;
    logic [W-1:0]   sq_d;
    logic [W-1:0]   sq_q;

    // Full-width product, keep only the top half.
    always_comb begin
        prod = {{W{1'b0}}, din} * {{W{1'b0}}, din};
        sq_d = prod[2*W-1:W];
    end

    // Pipeline register; asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign dout = sq_q;

endmodule

// File: rtl/breath_env.sv
// Four-phase brightness envelope (rise, hold high, fall, hold low) that
// advances once every PRESCALE PWM periods. The duty value min follows
// level through one register, or through the gamma squarer plus one
// register when BREATH_GAMMA_EN is defined.
module breath_env
    import breath_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                period_tick,
    input  logic [PWM_BITS-1:0] step,
    output logic [PWM_BITS-1:0] min,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase,
    output logic                cycle_done
);

    localparam int PS_W   = cnt_width(PRESCALE);
    localparam int HOLD_W = cnt_width(HOLD_STEPS);

    localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] LMAX      = PWM_BITS'(lmax(PWM_BITS));
    localparam logic [PWM_BITS:0]   LMAX_X    = {1'b0, LMAX};

    logic [PS_W-1:0]     ps_q, ps_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    phase_e              phase_q, phase_d;
    logic                cd_q, cd_d;
    logic [PWM_BITS-1:0] min_q, min_d;

    logic                advance;
    logic [PWM_BITS:0]   sum_x;
    logic [PWM_BITS:0]   level_x;
    logic [PWM_BITS:0]   step_x;

    assign advance = period_tick & enable & (ps_q == PS_LAST);

    // Prescaler: counts accepted period ticks, wraps on the advance tick.
    always_comb begin
        ps_d = ps_q;
        if (period_tick && enable) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        end
    end

    // Envelope FSM next state; widened arithmetic so nothing wraps.
    always_comb begin
        level_x = {1'b0, level_q};
        step_x  = {1'b0, step};
        sum_x   = level_x + step_x;
        level_d = level_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        cd_d    = 1'b0;
        if (advance) begin
            case (phase_q)
                RISE: begin
                    if (sum_x >= LMAX_X) begin
                        level_d = LMAX;
                        phase_d = HOLD_HI;
                        hold_d  = '0;
                    end else begin
                        level_d = sum_x[PWM_BITS-1:0];
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        phase_d = FALL;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                FALL: begin
                    if (level_x <= step_x) begin
                        level_d = '0;
                        phase_d = HOLD_LO;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q - step;
                    end
                end
                default: begin
                    if (hold_q == HOLD_LAST) begin
                        phase_d = RISE;
                        cd_d    = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BREATH_GAMMA_EN
    logic [PWM_BITS-1:0] sq;

    gamma_sq #(
        .W (PWM_BITS)
    ) u_gamma_sq (
        .clk  (clk),
        .rst  (rst),
        .din  (level_q),
        .dout (sq)
    );

    // Duty value follows the squared level.
    always_comb begin
        min_d = sq;
    end
`else
    // Duty value follows the linear level.
    always_comb begin
        min_d = level_q;
    end
`endif

    // State registers; min keeps tracking level even while frozen so it
    // never lags a frozen level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q    <= '0;
            hold_q  <= '0;
            level_q <= '0;
            phase_q <= RISE;
            cd_q    <= 1'b0;
            min_q   <= '0;
        end else begin
            ps_q    <= ps_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            phase_q <= phase_d;
            cd_q    <= cd_d;
            min_q   <= min_d;
        end
    end

    assign min        = min_q;
    assign level      = level_q;
    assign phase      = phase_q;
    assign cycle_done = cd_q;

endmodule
